// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration slave.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_PWM_LO    = 7'd2;
    localparam logic [6:0] ADDR_PWM_HI    = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [6:0] MAX_ADDR   = 7'h04;

endpackage

// File: rtl/spi_cfg_ctrl_sync_edge.sv
// Multi-flop synchronizer with rise/fall detect against one extra copy.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI mode-0 write-only configuration register file, 16-bit frames.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = spi_cfg_pkg::MAX_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .dout(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    assign unused_edges = ^{ncs_fall, sclk_s, sclk_fall, copi_rise, copi_fall};

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] shift;
    logic        accept;

    assign accept = (cnt == FRAME_BITS) && shift[15] && (shift[14:8] <= MAX_ADDR);

    // IDLE starts on a low synced ncs, so a fall that lands during COMMIT is still caught
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            shift           <= '0;
            wr_strobe       <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ncs_s) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        shift <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && cnt != FRAME_BITS) begin
                        shift <= {shift[14:0], copi_s};
                        cnt   <= cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (accept) begin
                        wr_strobe <= 1'b1;
                        unique case (1'b1)
                            shift[14:8] == ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift[7:0];
                            shift[14:8] == ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift[7:0];
                            shift[14:8] == ADDR_PWM_LO:    en_reg_pwm_7_0  <= shift[7:0];
                            shift[14:8] == ADDR_PWM_HI:    en_reg_pwm_15_8 <= shift[7:0];
                            shift[14:8] == ADDR_DUTY:      pwm_duty_cycle  <= shift[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_cfg_ctrl.md
SPI_CFG_CTRL -- requirements
Module: spi_cfg_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI input; legal values 2 to 3.
REQ-002 Parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 clk, input, 1 bit: single system clock, 10 MHz nominal; all logic is on its rising edge.
REQ-004 rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 sclk, input, 1 bit: SPI serial clock, asynchronous to clk, at most clk/5.
REQ-006 ncs, input, 1 bit: SPI chip select, active-low, asynchronous to clk.
REQ-007 copi, input, 1 bit: SPI data from the controller to this block.
REQ-008 en_reg_out_7_0, output, 8 bits: output-enable configuration for uo_out.
REQ-009 en_reg_out_15_8, output, 8 bits: output-enable configuration for uio_out.
REQ-010 en_reg_pwm_7_0, output, 8 bits: PWM-select configuration for uo_out.
REQ-011 en_reg_pwm_15_8, output, 8 bits: PWM-select configuration for uio_out.
REQ-012 pwm_duty_cycle, output, 8 bits: duty cycle for the shared PWM generator.
REQ-013 wr_strobe, output, 1 bit: one-cycle pulse on each accepted register write.

Function
REQ-014 Protocol: SPI mode 0; copi is sampled on the sclk rising edge; MSB first; each frame is 16 bits.
REQ-015 Frame format: bit15 = R/W (1 = write); bits14:8 = address; bits7:0 = data.
REQ-016 sclk, ncs and copi each pass through SYNC_STAGES flops; only the synchronized versions are used.
REQ-017 Edge detection compares the synchronized signal with one extra registered copy; a sclk rise is synced 0 then 1, and an ncs rise is synced 0 then 1.
REQ-018 FSM states: IDLE, SHIFT, COMMIT.
REQ-019 IDLE to SHIFT when synced ncs falls; the bit counter and shift register clear on this transition.
REQ-020 In SHIFT, each synced sclk rise shifts copi into shift[0] and increments a 5-bit counter.
REQ-021 The counter saturates at 16; further sclk rises in the same frame are ignored and the shift register is frozen.
REQ-022 SHIFT to COMMIT when synced ncs rises; COMMIT returns to IDLE after exactly 1 cycle.
REQ-023 Acceptance rule: in COMMIT, the write is accepted only if count == 16, R/W == 1 and address <= MAX_ADDR.
REQ-024 On acceptance, the addressed register loads the data on the COMMIT clock edge, and wr_strobe is high for that one cycle.
REQ-025 Register map: address 0 = en_reg_out_7_0, 1 = en_reg_out_15_8, 2 = en_reg_pwm_7_0, 3 = en_reg_pwm_15_8, 4 = pwm_duty_cycle.
REQ-026 Rejected frames leave all registers unchanged and produce no wr_strobe; rejected means short (count < 16), read (R/W = 0), or out-of-range address.
REQ-027 Latency: a register update is visible SYNC_STAGES+2 clk cycles after the first clk edge that samples ncs high.
REQ-028 Read frames produce no output traffic; there is no CIPO.
REQ-029 If ncs rises and falls again within the synchronizer window, the block completes COMMIT, then IDLE detects the new falling edge; no frame is merged.
REQ-030 sclk edges seen while in IDLE or COMMIT are ignored.

Reset
REQ-031 When rst_n is low, all five configuration registers and wr_strobe are 0 immediately, independent of clk.
REQ-032 Reset also sets the FSM to IDLE, the counter to 0, the shift register to 0, and all synchronizer flops to ncs = 1, sclk = 0, copi = 0.
REQ-033 Reset asserted mid-frame discards the frame; after release, no write occurs until a complete new frame with ncs falling.

Structure
REQ-034 A shared package spi_cfg_pkg holds the FSM state enum, the address constants ADDR_EN_OUT_LO through ADDR_DUTY, FRAME_BITS = 16, and MAX_ADDR.
REQ-035 A single sub-module sync_edge (a synchronizer plus rise/fall detector, parameterised by SYNC_STAGES) is instantiated three times.
REQ-036 The top level contains only the FSM, the shift/count logic and the register file; it has no combinational paths from the SPI pins to outputs.

Verification
REQ-037 Write 0x80F0 (write to address 0, data 0xF0) -> en_reg_out_7_0 = 0xF0, a single wr_strobe pulse, and all other registers 0.
REQ-038 Write 0x8480 (address 4, data 0x80) -> pwm_duty_cycle = 0x80 within SYNC_STAGES+2 cycles of ncs rising.
REQ-039 Read frame 0x0155 followed by out-of-range write 0x8A55 -> all registers unchanged, and no wr_strobe.
REQ-040 Write 0x82FF with ncs raised after 12 bits -> rejected; then write 17 bits 0x82AA plus an extra 1 -> en_reg_pwm_7_0 = 0xAA.
REQ-041 Assert rst_n low after bit 9 of write 0x83CC -> all outputs 0 immediately; after release, write 0x83CC -> en_reg_pwm_15_8 = 0xCC.
REQ-042 Back-to-back writes 0x8111 and 0x8122, separated by 1 sclk period with ncs high -> en_reg_out_15_8 is 0x11 and then 0x22, with two wr_strobe pulses.
